// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared CPU/memory typedefs and arbiter constants
package mem_arbiter_pkg;

    // CPU instruction opcodes decoded by the control FSM
    typedef enum logic [2:0] {
        OP_LDA = 3'd0,
        OP_STA = 3'd1,
        OP_ADD = 3'd2,
        OP_SUB = 3'd3,
        OP_JMP = 3'd4,
        OP_JZ  = 3'd5,
        OP_NOP = 3'd6,
        OP_HLT = 3'd7
    } opcode_t;

    // CPU control FSM states
    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    // Memory arbiter ownership states
    typedef enum logic [1:0] {
        CPU_OWN  = 2'd0,
        HOST_GNT = 2'd1,
        HOST_ACK = 2'd2
    } arb_state_t;

    // Host wait counter width and its saturation value
    localparam int         WAIT_CNT_W   = 4;
    localparam logic [3:0] WAIT_CNT_SAT = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/host arbiter for the shared single-port memory
module mem_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    import mem_arbiter_pkg::*;

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    arb_state_t            state;
    arb_state_t            next_state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  cpu_busy;
    logic                  host_win;

    assign cpu_busy  = cpu_rd | cpu_wr;
    // Host wins when the CPU leaves memory idle or it has waited long enough
    assign host_win  = host_req && (!cpu_busy || (wait_cnt >= WAIT_LIMIT));
    assign cpu_rdata = mem_rdata;

    // Ownership state register; reset aborts any host transaction in flight
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= CPU_OWN;
        end else begin
            state <= next_state;
        end
    end

    // Count cycles a pending host request spends behind a busy CPU
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wait_cnt <= '0;
        end else begin
            case (state)
                CPU_OWN: begin
                    if (!host_req) begin
                        wait_cnt <= '0;
                    end else if (cpu_busy && (wait_cnt != WAIT_CNT_SAT)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HOST_GNT: wait_cnt <= '0;
                default:  wait_cnt <= wait_cnt;
            endcase
        end
    end

    // Capture memory read data during the host's grant cycle
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            host_rdata <= '0;
        end else if (state == HOST_GNT) begin
            host_rdata <= mem_rdata;
        end
    end

    // Next-state decode, Moore handshake outputs and the memory port mux
    always_comb begin
        next_state = state;
        host_gnt   = 1'b0;
        host_ack   = 1'b0;
        cpu_stall  = 1'b0;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_rd     = cpu_rd;
        mem_wr     = cpu_wr;
        case (state)
            CPU_OWN: begin
                if (host_win) begin
                    next_state = HOST_GNT;
                end
            end
            HOST_GNT: begin
                host_gnt   = 1'b1;
                cpu_stall  = 1'b1;
                mem_addr   = host_addr;
                mem_wdata  = host_wdata;
                mem_rd     = !host_we;
                mem_wr     = host_we;
                next_state = HOST_ACK;
            end
            HOST_ACK: begin
                host_ack   = 1'b1;
                next_state = CPU_OWN;
            end
            default: begin
                next_state = CPU_OWN;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int MW = 4;

    logic          clk;
    logic          rst_;
    logic          cpu_rd;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_WAIT  (MW)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .host_req  (host_req),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_gnt  (host_gnt),
        .host_ack  (host_ack),
        .host_rdata(host_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: combinational read, synchronous write, plus a preload port
    logic [DW-1:0]    mem [0:31];
    logic             pl_en;
    logic [AW-1:0]    pl_addr;
    logic [DW-1:0]    pl_data;
    logic [AW+DW-1:0] wr_log [$];

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_log.push_back({mem_addr, mem_wdata});
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    // Scoreboard of expected host completions
    typedef struct {
        logic          care;
        logic [DW-1:0] data;
    } ack_exp_t;
    ack_exp_t ack_q [$];

    always @(negedge clk) begin
        if (rst_ && host_ack) begin
            ack_cnt++;
            if (ack_q.size() == 0) begin
                chk("spurious_ack_queue_depth", 32'd0, 32'd1);
            end else begin
                ack_exp_t e;
                e = ack_q.pop_front();
                if (e.care) chk("sb_host_rdata", 32'(host_rdata), 32'(e.data));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        cyc();
        pl_en   = 1'b0;
    endtask

    task automatic cpu_idle();
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
    endtask

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] pre;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int acks_before;

        vecs[0] = '{1'b1, 1'b0, 5'h01, 8'h00, 8'hC3, 1'b1, 1'b0, 5'h01, 8'h00, 8'hC3};
        vecs[1] = '{1'b0, 1'b1, 5'h02, 8'h5A, 8'h11, 1'b0, 1'b1, 5'h02, 8'h5A, 8'h11};
        vecs[2] = '{1'b1, 1'b0, 5'h1E, 8'hFF, 8'h7E, 1'b1, 1'b0, 5'h1E, 8'hFF, 8'h7E};
        vecs[3] = '{1'b0, 1'b0, 5'h10, 8'h44, 8'h99, 1'b0, 1'b0, 5'h10, 8'h44, 8'h99};

        rst_       = 1'b0;
        pl_en      = 1'b0;
        pl_addr    = '0;
        pl_data    = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        cpu_idle();

        // Reset state: handshake outputs low, memory port follows the CPU
        #12;
        cpu_wr    = 1'b1;
        cpu_addr  = 5'h07;
        cpu_wdata = 8'h5A;
        #1;
        chk("rst_host_gnt",   32'(host_gnt),   32'd0);
        chk("rst_host_ack",   32'(host_ack),   32'd0);
        chk("rst_cpu_stall",  32'(cpu_stall),  32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'h00);
        chk("rst_mem_wr",     32'(mem_wr),     32'd1);
        chk("rst_mem_addr",   32'(mem_addr),   32'h07);
        chk("rst_mem_wdata",  32'(mem_wdata),  32'h5A);
        cpu_idle();
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        cyc();

        // Table: CPU pass-through while no host request is pending
        for (int i = 0; i < 4; i++) begin
            cpu_idle();
            preload(vecs[i].addr, vecs[i].pre);
            cpu_rd    = vecs[i].rd;
            cpu_wr    = vecs[i].wr;
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            @(negedge clk);
            chk($sformatf("v%0d_mem_rd", i),    32'(mem_rd),    32'(vecs[i].e_rd));
            chk($sformatf("v%0d_mem_wr", i),    32'(mem_wr),    32'(vecs[i].e_wr));
            chk($sformatf("v%0d_mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_addr));
            chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wdata));
            chk($sformatf("v%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].e_rdata));
            chk($sformatf("v%0d_cpu_stall", i), 32'(cpu_stall), 32'd0);
            chk($sformatf("v%0d_host_gnt", i),  32'(host_gnt),  32'd0);
            cyc();
        end
        cpu_idle();

        // Host read with idle CPU: grant next cycle, ack the cycle after
        preload(5'h0A, 8'h3C);
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 5'h0A;
        ack_q.push_back('{1'b1, 8'h3C});
        @(negedge clk);
        chk("t2_k0_gnt", 32'(host_gnt), 32'd0);
        @(negedge clk);
        chk("t2_gnt",      32'(host_gnt),  32'd1);
        chk("t2_mem_rd",   32'(mem_rd),    32'd1);
        chk("t2_mem_wr",   32'(mem_wr),    32'd0);
        chk("t2_mem_addr", 32'(mem_addr),  32'h0A);
        chk("t2_stall",    32'(cpu_stall), 32'd1);
        @(negedge clk);
        chk("t2_ack",        32'(host_ack),   32'd1);
        chk("t2_ack_gnt",    32'(host_gnt),   32'd0);
        chk("t2_ack_stall",  32'(cpu_stall),  32'd0);
        chk("t2_host_rdata", 32'(host_rdata), 32'h3C);
        @(posedge clk);
        #1;
        host_req = 1'b0;
        @(negedge clk);
        chk("t2_after_gnt", 32'(host_gnt), 32'd0);
        chk("t2_after_ack", 32'(host_ack), 32'd0);

        // Host write with idle CPU, then CPU reads it back
        cyc();
        wr_log.delete();
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'h1F;
        host_wdata = 8'hA5;
        ack_q.push_back('{1'b0, 8'h00});
        n = 0;
        @(negedge clk);
        while (!host_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t3_ack_seen", 32'(host_ack), 32'd1);
        @(posedge clk);
        #1;
        host_req = 1'b0;
        host_we  = 1'b0;
        chk("t3_write_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() >= 1) chk("t3_write_entry", 32'(wr_log[0]), 32'({5'h1F, 8'hA5}));
        cpu_rd   = 1'b1;
        cpu_addr = 5'h1F;
        @(negedge clk);
        chk("t3_cpu_rdata", 32'(cpu_rdata), 32'hA5);
        cyc();
        cpu_idle();

        // CPU read held: host forced in after MAX_WAIT cycles
        cyc();
        cpu_rd    = 1'b1;
        cpu_addr  = 5'h00;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 5'h0A;
        ack_q.push_back('{1'b1, 8'h3C});
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("t4_k%0d_gnt", k),   32'(host_gnt),  32'(k == 5));
            chk($sformatf("t4_k%0d_stall", k), 32'(cpu_stall), 32'(k == 5));
            chk($sformatf("t4_k%0d_ack", k),   32'(host_ack),  32'(k == 6));
        end
        @(posedge clk);
        #1;
        host_req = 1'b0;
        cpu_idle();

        // Colliding writes: host lands first, CPU re-presents and wins
        cyc();
        wr_log.delete();
        cpu_wr     = 1'b1;
        cpu_addr   = 5'h03;
        cpu_wdata  = 8'h11;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'h03;
        host_wdata = 8'h22;
        ack_q.push_back('{1'b0, 8'h00});
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("t5_gnt",       32'(host_gnt),  32'd1);
                chk("t5_mem_wdata", 32'(mem_wdata), 32'h22);
            end
        end
        @(posedge clk);
        #1;
        cpu_idle();
        host_req = 1'b0;
        host_we  = 1'b0;
        chk("t5_write_count", 32'(wr_log.size()), 32'd7);
        for (int i = 0; i < 7 && i < wr_log.size(); i++) begin
            chk($sformatf("t5_write_%0d", i), 32'(wr_log[i]),
                (i == 5) ? 32'({5'h03, 8'h22}) : 32'({5'h03, 8'h11}));
        end
        chk("t5_final_mem03", 32'(mem[3]), 32'h11);

        // Host request held across ack: grants three cycles apart
        cyc();
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 5'h0A;
        ack_q.push_back('{1'b1, 8'h3C});
        ack_q.push_back('{1'b1, 8'h3C});
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("t6_k%0d_gnt", k), 32'(host_gnt), 32'(k == 1 || k == 4));
            chk($sformatf("t6_k%0d_ack", k), 32'(host_ack), 32'(k == 2 || k == 5));
        end
        @(posedge clk);
        #1;
        host_req = 1'b0;
        @(negedge clk);
        chk("t6_k6_gnt", 32'(host_gnt), 32'd0);
        @(negedge clk);
        chk("t6_k7_gnt", 32'(host_gnt), 32'd0);

        // Reset asserted during a host write grant aborts it
        cyc();
        preload(5'h04, 8'h00);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'h04;
        host_wdata = 8'h77;
        @(negedge clk);
        @(negedge clk);
        chk("t1_gnt_before", 32'(host_gnt), 32'd1);
        chk("t1_mem_wr_before", 32'(mem_wr), 32'd1);
        acks_before = ack_cnt;
        #1;
        rst_ = 1'b0;
        #1;
        chk("t1_gnt_reset",    32'(host_gnt),   32'd0);
        chk("t1_mem_wr_reset", 32'(mem_wr),     32'd0);
        chk("t1_stall_reset",  32'(cpu_stall),  32'd0);
        chk("t1_rdata_reset",  32'(host_rdata), 32'h00);
        host_req = 1'b0;
        host_we  = 1'b0;
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        chk("t1_no_ack",     32'(ack_cnt), 32'(acks_before));
        chk("t1_mem04_kept", 32'(mem[4]),  32'h00);

        chk("sb_queue_drained", 32'(ack_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port instruction/data memory between the CPU (the control FSM plus its address mux) and a host port used for program load, readback and debug.
- The CPU has default priority.
- A host request is granted immediately when the CPU is not accessing memory. Otherwise it is granted after a bounded wait, during which the CPU is stalled for one cycle.
- Sits between the CPU datapath/control and the memory. cpu_stall feeds the control FSM's state-advance enable.

Parameters:
- ADDR_WIDTH, 5, memory address width.
- DATA_WIDTH, 8, memory data width.
- MAX_WAIT, 4, max cycles a host request waits behind a busy CPU before forced grant; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst_  input  1  reset.
- cpu_rd  input  1  CPU memory read strobe.
- cpu_wr  input  1  CPU memory write strobe.
- cpu_addr  input  ADDR_WIDTH  CPU address.
- cpu_wdata  input  DATA_WIDTH  CPU write data.
- cpu_rdata  output  DATA_WIDTH  read data to CPU; always equals mem_rdata.
- cpu_stall  output  1  CPU must hold its state this cycle.
- host_req  input  1  host request; held until host_ack.
- host_we  input  1  host write (1) / read (0); stable while host_req is high.
- host_addr  input  ADDR_WIDTH  host address.
- host_wdata  input  DATA_WIDTH  host write data.
- host_gnt  output  1  host owns memory this cycle.
- host_ack  output  1  one-cycle completion pulse.
- host_rdata  output  DATA_WIDTH  registered read data; valid while host_ack is high.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rd  output  1  memory read enable.
- mem_wr  output  1  memory write enable.
- mem_rdata  input  DATA_WIDTH  memory read data; combinational read, synchronous write.

Behaviour:
- Reset: rst_ is asynchronous, active-low; clock clk. Reset forces state CPU_OWN and wait_cnt=0.
- Reset values:
  - host_gnt=0, host_ack=0, cpu_stall=0, host_rdata=0.
  - mem_* follow the cpu_* inputs, because the state is CPU_OWN.
- Reset mid-transaction: the transaction is aborted with no ack. mem_wr drops immediately. The host must reissue.
- State type: arb_state_t, with states CPU_OWN, HOST_GNT, HOST_ACK. Outputs host_gnt, host_ack and cpu_stall are Moore, decoded from the state register.
- Define cpu_busy = cpu_rd | cpu_wr.

CPU_OWN:
- mem_addr/mem_wdata/mem_rd/mem_wr = cpu_addr/cpu_wdata/cpu_rd/cpu_wr.
- cpu_stall=0.
- Go to HOST_GNT when host_req && (!cpu_busy || wait_cnt >= MAX_WAIT).
- Otherwise, if host_req && cpu_busy, wait_cnt increments, saturating at 15.
- If host_req=0, wait_cnt clears.

HOST_GNT (exactly 1 cycle):
- mem_addr=host_addr, mem_wdata=host_wdata, mem_rd=!host_we, mem_wr=host_we.
- host_gnt=1, cpu_stall=1.
- host_rdata <= mem_rdata at the clock edge (captured for writes too; don't-care).
- wait_cnt clears. Next state is HOST_ACK.

HOST_ACK (exactly 1 cycle):
- host_ack=1. Memory mux is back to the CPU; cpu_stall=0.
- Next state is CPU_OWN unconditionally.

Host handshake:
- Host deasserts host_req in the cycle after host_ack.
- If host_req is still high in the following CPU_OWN cycle, it is a new request.
- Minimum spacing between host grants is therefore 3 cycles. Back-to-back grants are impossible.

CPU stall and latency:
- A CPU access attempted during HOST_GNT is not performed. The stalled controller re-presents it the next cycle.
- Host worst-case latency, request to host_gnt: MAX_WAIT+1 cycles.
- Host best-case latency: 1 cycle (CPU idle).
- CPU loses at most 1 cycle per host transaction.

Other rules:
- Simultaneous cpu_wr and host write to the same address: the host write lands first (HOST_GNT); the CPU write lands the next cycle. The final value is the CPU's.
- cpu_rd and cpu_wr both high is illegal. The arbiter passes both through unchanged; no checking.

Decomposition:
- Add arb_state_t (enum: CPU_OWN, HOST_GNT, HOST_ACK) to the shared typedefs package, alongside opcode_t/state_t.
- wait_cnt stays a 4-bit logic inside the module.
- No sub-module: the counter and 3-state FSM are too small to split.
- The memory is the existing memory block, instantiated at the top level.

Test Plan (MAX_WAIT=4):
1. Assert rst_=0 during HOST_GNT (host write, addr 5'h04) -> host_gnt=0 immediately, no host_ack ever, mem_wr follows cpu_wr, host_rdata=8'h00.
2. CPU idle, host read addr 5'h0A with mem[0A]=8'h3C -> next cycle host_gnt=1, mem_rd=1, mem_addr=0A, cpu_stall=1; following cycle host_ack=1, host_rdata=8'h3C; then CPU_OWN.
3. CPU idle, host write addr 5'h1F data 8'hA5 -> mem_wr=1 for exactly one cycle; a later CPU read of 1F gives cpu_rdata=8'hA5.
4. cpu_rd held 1 continuously, host_req rises at t0 -> host_gnt=1 only in cycle t0+5, cpu_stall=1 only that cycle, host_ack at t0+6.
5. Forced grant of host write addr 5'h03 data 8'h22 while cpu_wr addr 5'h03 data 8'h11 is held -> mem writes 22 then 11 on consecutive edges; final mem[03]=8'h11.
6. host_req held high across host_ack, CPU idle -> second host_gnt occurs exactly 3 cycles after the first, with one intervening CPU_OWN cycle.
